store_formatter: RTL and testbench
==================================

# store_formatter

Store-side data formatter for the 16-bit MIPS-style datapath, the write-direction counterpart of the immediate/load extender. It accepts a store request (address, register data, size) from the EX/MEM stage, places the byte or halfword on the correct memory lanes with byte enables, and runs the memory write handshake through to completion. An optional read-modify-write mode supports memories without byte strobes.

## Interface
- ADDR_W, 16, byte address width; data width is fixed at 16 bits (2 byte lanes).
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_addr  input  ADDR_W  byte address.
- req_data  input  16  register data; bytes use [7:0].
- req_size  input  2  0 = byte, 1 = halfword, 2/3 = illegal.
- done  output  1  one-cycle pulse: store committed to memory.
- err  output  1  one-cycle pulse: request rejected (misaligned or illegal size).
- mem_we  output  1  write strobe, held until mem_ack.
- mem_re  output  1  read strobe (RMW mode only, else tied 0).
- mem_addr  output  ADDR_W  halfword-aligned address, {req_addr[ADDR_W-1:1],1'b0}.
- mem_wdata  output  16  lane-placed write data.
- mem_be  output  2  byte enables, bit0 = bits [7:0].
- mem_rdata  input  16  read data (RMW mode).
- mem_ack  input  1  memory completes current access this cycle.

## Operation
- Little-endian lanes: addr[0]=0 is the low byte.
- Byte store: mem_wdata = {d[7:0],d[7:0]}, mem_be = addr[0] ? 2'b10 : 2'b01.
- Halfword store, addr[0]=0: mem_wdata = d, mem_be = 2'b11.
- Halfword with addr[0]=1, or size 2/3: err pulse, no memory access, done not asserted.
- Request, address, data and size are registered on acceptance (req_valid & req_ready); inputs may change afterwards.
- FSM states: IDLE, READ (RMW only), WRITE.
  - IDLE: req_ready=1. On a legal accept -> WRITE (or READ for RMW byte store). On an illegal accept -> stay IDLE, err next cycle.
  - READ: mem_re=1 until mem_ack; capture mem_rdata on ack -> WRITE.
  - WRITE: mem_we=1 until mem_ack; on ack -> IDLE with done pulsed in the following cycle.
- A new request may be accepted in the same cycle done is high (back-to-back).
- mem_addr/mem_wdata/mem_be are stable for the whole strobe; zero outside strobes.

## Timing
- Reset values: req_ready=1, done=0, err=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, mem_be=0; FSM in IDLE.
- Accept in cycle N -> mem_we high in N+1; ack in cycle M ≥ N+1 -> mem_we low and done=1 in M+1.
- Zero-wait memory: 2 cycles per store (non-RMW); 3 cycles per RMW byte store.
- Error: accept in N -> err=1 in N+1, req_ready stays 1.
- mem_ack outside a strobe is ignored.
- Reset asserted mid-transaction: strobes drop immediately (async), transaction discarded, no done/err.

## Configuration
- STORE_RMW_EN defined: memory has no byte strobes. Byte stores do READ then WRITE; WRITE data = captured word with the target byte replaced; mem_be forced 2'b11 on every write. Halfword stores skip READ.
- STORE_RMW_EN undefined: READ state and mem_re logic compiled out (mem_re tied 0); mem_rdata unused; single write with byte enables.

## Structure
- Shared package store_pkg: size codes (SZ_BYTE, SZ_HALF), FSM state enum, lane-enable constants.
- One combinational sub-module store_lane_merge: takes addr[0], size, data, optional old word; returns wdata, be, and illegal flag. FSM and registers stay in store_formatter.

## Test plan
- Byte store addr 0x0011, data 0x12AB, ack same cycle as we -> mem_addr 0x0010, wdata 0xABAB, be 2'b10, done 2 cycles after accept.
- Halfword store addr 0x0020, data 0xBEEF, ack after 3 wait cycles -> mem_we held 4 cycles, be 2'b11, one done pulse.
- Halfword at addr 0x0021 and size 3 at 0x0020 -> err pulse each, mem_we never asserted, req_ready stays 1.
- Back-to-back: second request presented in the done cycle -> accepted, mem_we next cycle, no bubble beyond FSM minimum.
- rst_n low while mem_we high with ack withheld -> mem_we 0 immediately, no done after reset release, next store completes normally.
- STORE_RMW_EN: byte store addr 0x0030, data 0x0077, mem_rdata 0x1234 -> mem_re then mem_we, wdata 0x1277, be 2'b11, done after 3 cycles with zero-wait ack.

Source files
------------

// File: rtl/store_pkg.sv
// Shared definitions for the store formatter: widths, size codes, lane
// enables, FSM state constants and the lane-merge result payload.
package store_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    // Store size codes; codes 2 and 3 are illegal
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    // Byte lane enables, bit0 covers data[7:0]
    localparam logic [BE_W-1:0] BE_LO  = 2'b01;
    localparam logic [BE_W-1:0] BE_HI  = 2'b10;
    localparam logic [BE_W-1:0] BE_ALL = 2'b11;

    // FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // Lane-merge result: placed write data, enables and reject flag
    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              illegal;
    } lane_t;

    // Halfword-aligned memory address for a byte address
    function automatic logic [ADDR_W-1:0] align_half(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/store_formatter_if.sv
// Store request bus plus memory write/read handshake.
//   slave  : store_formatter view (takes requests, drives memory strobes)
//   master : requester + memory view
interface store_formatter_if;

    logic                        req_valid;
    logic                        req_ready;
    logic [store_pkg::ADDR_W-1:0] req_addr;
    logic [store_pkg::DATA_W-1:0] req_data;
    logic [1:0]                  req_size;
    logic                        done;
    logic                        err;
    logic                        mem_we;
    logic                        mem_re;
    logic [store_pkg::ADDR_W-1:0] mem_addr;
    logic [store_pkg::DATA_W-1:0] mem_wdata;
    logic [store_pkg::BE_W-1:0]   mem_be;
    logic [store_pkg::DATA_W-1:0] mem_rdata;
    logic                        mem_ack;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata, mem_ack,
        output req_ready, done, err, mem_we, mem_re, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata, mem_ack,
        input  req_ready, done, err, mem_we, mem_re, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/store_lane_merge.sv
// Combinational lane placement for a store.
//   addr_lsb : byte address bit 0 (1 = high lane)
//   size     : store size code
//   data     : register data, bytes in [7:0]
//   old_word : previously read memory word (STORE_RMW_EN builds only)
//   lane_c   : placed write data, byte enables, illegal flag
// With STORE_RMW_EN defined the target byte is merged into old_word and all
// lanes are enabled.
module store_lane_merge
    import store_pkg::*;
(
    input  logic              addr_lsb,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] data,
`ifdef STORE_RMW_EN
    input  logic [DATA_W-1:0] old_word,
`endif
    output lane_t             lane_c
);

    logic illegal;

    // Misaligned halfword or reserved size code
    assign illegal = size[1] | ((size == SZ_HALF) & addr_lsb);

    always_comb begin
        lane_c         = '0;
        lane_c.illegal = illegal;
        if (!illegal) begin
            if (size == SZ_HALF) begin
                lane_c.wdata = data;
                lane_c.be    = BE_ALL;
            end else begin
`ifdef STORE_RMW_EN
                lane_c.wdata = addr_lsb ? {data[7:0], old_word[7:0]}
                                        : {old_word[15:8], data[7:0]};
                lane_c.be    = BE_ALL;
`else
                lane_c.wdata = {data[7:0], data[7:0]};
                lane_c.be    = addr_lsb ? BE_HI : BE_LO;
`endif
            end
        end
    end

endmodule

// File: rtl/store_formatter.sv
// Store-side formatter: accepts a store request, places data on the byte
// lanes and runs the memory write handshake to completion.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : store_formatter_if.slave (request, done/err, memory port)
// Optional build macro STORE_RMW_EN: byte stores become read-modify-write
// for memories without byte strobes.
module store_formatter
    import store_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    store_formatter_if.slave  bus
);

    logic [1:0]        state_q, state_nxt;
    logic              ready_q, done_q, err_q, we_q;
    logic              done_nxt, err_nxt, we_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [BE_W-1:0]   be_q, be_nxt;
    logic              accept;
    lane_t             lane_c;

    assign accept = bus.req_valid & ready_q;

`ifdef STORE_RMW_EN
    logic       re_q, re_nxt;
    logic       lsb_q, lsb_nxt;
    logic [7:0] byte_q, byte_nxt;
    logic       in_read;

    // In READ the merge works on the captured byte and the returned word
    assign in_read = (state_q == ST_READ);

    store_lane_merge u_merge (
        .addr_lsb (in_read ? lsb_q : bus.req_addr[0]),
        .size     (in_read ? SZ_BYTE : bus.req_size),
        .data     (in_read ? {8'h00, byte_q} : bus.req_data),
        .old_word (bus.mem_rdata),
        .lane_c   (lane_c)
    );

    assign bus.mem_re = re_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.mem_rdata;

    store_lane_merge u_merge (
        .addr_lsb (bus.req_addr[0]),
        .size     (bus.req_size),
        .data     (bus.req_data),
        .lane_c   (lane_c)
    );

    assign bus.mem_re = 1'b0;
`endif

    // Next state and next registered outputs; memory fields zero outside strobes
    always_comb begin
        state_nxt = state_q;
        we_nxt    = 1'b0;
        addr_nxt  = '0;
        wdata_nxt = '0;
        be_nxt    = '0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
`ifdef STORE_RMW_EN
        re_nxt    = 1'b0;
        lsb_nxt   = lsb_q;
        byte_nxt  = byte_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (lane_c.illegal) begin
                        err_nxt = 1'b1;
                    end
`ifdef STORE_RMW_EN
                    else if (bus.req_size == SZ_BYTE) begin
                        state_nxt = ST_READ;
                        re_nxt    = 1'b1;
                        addr_nxt  = align_half(bus.req_addr);
                        lsb_nxt   = bus.req_addr[0];
                        byte_nxt  = bus.req_data[7:0];
                    end
`endif
                    else begin
                        state_nxt = ST_WRITE;
                        we_nxt    = 1'b1;
                        addr_nxt  = align_half(bus.req_addr);
                        wdata_nxt = lane_c.wdata;
                        be_nxt    = lane_c.be;
                    end
                end
            end
            ST_READ: begin
`ifdef STORE_RMW_EN
                addr_nxt = addr_q;
                if (bus.mem_ack) begin
                    state_nxt = ST_WRITE;
                    we_nxt    = 1'b1;
                    wdata_nxt = lane_c.wdata;
                    be_nxt    = lane_c.be;
                end else begin
                    re_nxt = 1'b1;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    we_nxt    = 1'b1;
                    addr_nxt  = addr_q;
                    wdata_nxt = wdata_q;
                    be_nxt    = be_q;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
`ifdef STORE_RMW_EN
            re_q    <= 1'b0;
            lsb_q   <= 1'b0;
            byte_q  <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            ready_q <= (state_nxt == ST_IDLE);
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            be_q    <= be_nxt;
`ifdef STORE_RMW_EN
            re_q    <= re_nxt;
            lsb_q   <= lsb_nxt;
            byte_q  <= byte_nxt;
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;

endmodule

// File: tb/tb_store_formatter.sv
// Self-checking bench for store_formatter: reset values, table vectors,
// randomized stores against a behavioural model, back-to-back, mid-store
// reset and (with STORE_RMW_EN) read-modify-write byte stores.
module tb_store_formatter;
    import store_pkg::*;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    store_formatter_if bus ();

    store_formatter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  size;
        int          waits;
        bit          err;
        logic [15:0] maddr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference: lane placement from the little-endian store rules
    function automatic void model(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s,
                                  output bit ill, output logic [15:0] ma,
                                  output logic [15:0] wd, output logic [1:0] be);
        ma  = 16'(a - 16'(a % 2));
        ill = 1'b0;
        wd  = '0;
        be  = '0;
        if (s == 2'd0) begin
            wd = 16'(32'(d[7:0]) * 257);
            be = 2'(1 << a[0]);
        end else if (s == 2'd1 && (a % 2) == 0) begin
            wd = d;
            be = 2'd3;
        end else begin
            ill = 1'b1;
        end
    endfunction

    // Present a request at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = s;
        chk("ready_at_issue", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        bus.req_data  = 16'($urandom);
        bus.req_size  = 2'($urandom);
    endtask

    // Strobe phase with 'waits' stall cycles; returns in the done cycle
    task automatic finish_write(input logic [15:0] ea, input logic [15:0] ew,
                                input logic [1:0] eb, input int waits);
        for (int i = 0; i <= waits; i++) begin
            chk("mem_we", 32'(bus.mem_we), 32'd1);
            chk("mem_re_in_write", 32'(bus.mem_re), 32'd0);
            chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(ew));
            chk("mem_be", 32'(bus.mem_be), 32'(eb));
            chk("done_early", 32'(bus.done), 32'd0);
            chk("ready_busy", 32'(bus.req_ready), 32'd0);
            bus.mem_ack = (i == waits);
            @(posedge clk);
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("we_drop", 32'(bus.mem_we), 32'd0);
        chk("ready_done", 32'(bus.req_ready), 32'd1);
    endtask

    // One idle cycle with a stray ack; everything must stay quiet
    task automatic idle_step();
        bus.mem_ack = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_err", 32'(bus.err), 32'd0);
        chk("idle_we", 32'(bus.mem_we), 32'd0);
        chk("idle_re", 32'(bus.mem_re), 32'd0);
        chk("idle_addr", 32'(bus.mem_addr), 32'd0);
        chk("idle_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("idle_be", 32'(bus.mem_be), 32'd0);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic check_err();
        chk("err_pulse", 32'(bus.err), 32'd1);
        chk("err_no_we", 32'(bus.mem_we), 32'd0);
        chk("err_done", 32'(bus.done), 32'd0);
        chk("err_ready", 32'(bus.req_ready), 32'd1);
        idle_step();
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.addr, v.data, v.size);
        if (v.err) check_err();
        else begin
            finish_write(v.maddr, v.wdata, v.be, v.waits);
            idle_step();
        end
    endtask

`ifdef STORE_RMW_EN
    task automatic rmw_byte(input logic [15:0] a, input logic [15:0] d,
                            input logic [15:0] rd, input logic [15:0] ew);
        issue(a, d, SZ_BYTE);
        chk("rmw_re", 32'(bus.mem_re), 32'd1);
        chk("rmw_no_we", 32'(bus.mem_we), 32'd0);
        chk("rmw_raddr", 32'(bus.mem_addr), 32'(align_half(a)));
        bus.mem_rdata = rd;
        bus.mem_ack   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        finish_write(align_half(a), ew, 2'b11, 0);
        idle_step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ill;
        logic [15:0] ma, wd, a, d;
        logic [1:0]  be, s;
        int          waits;

        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        vecs[0] = '{16'h0011, 16'h12AB, 2'd0, 0, 1'b0, 16'h0010, 16'hABAB, 2'b10};
        vecs[1] = '{16'h0020, 16'hBEEF, 2'd1, 3, 1'b0, 16'h0020, 16'hBEEF, 2'b11};
        vecs[2] = '{16'h0021, 16'h5555, 2'd1, 0, 1'b1, 16'h0000, 16'h0000, 2'b00};
        vecs[3] = '{16'h0020, 16'h6666, 2'd3, 0, 1'b1, 16'h0000, 16'h0000, 2'b00};
        vecs[4] = '{16'h0010, 16'hFFCD, 2'd0, 1, 1'b0, 16'h0010, 16'hCDCD, 2'b01};
        vecs[5] = '{16'hFFFE, 16'h5A5A, 2'd1, 0, 1'b0, 16'hFFFE, 16'h5A5A, 2'b11};
        vecs[6] = '{16'h1235, 16'h0000, 2'd2, 0, 1'b1, 16'h0000, 16'h0000, 2'b00};
        vecs[7] = '{16'hFFFF, 16'h3377, 2'd0, 2, 1'b0, 16'hFFFE, 16'h7777, 2'b10};

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_re", 32'(bus.mem_re), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_be", 32'(bus.mem_be), 32'd0);
        rst_n = 1'b1;
        idle_step();

        for (int i = 0; i < 8; i++) begin
`ifdef STORE_RMW_EN
            if (vecs[i].size == SZ_BYTE) continue;
`endif
            run_vec(vecs[i]);
        end

`ifdef STORE_RMW_EN
        rmw_byte(16'h0030, 16'h0077, 16'h1234, 16'h1277);
        rmw_byte(16'h0031, 16'hFFAA, 16'h1234, 16'hAA34);
`else
        // Randomized stores against the model
        for (int n = 0; n < 40; n++) begin
            a = 16'($urandom);
            d = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: s = 2'd0;
                4, 5, 6, 7: s = 2'd1;
                8:          s = 2'd2;
                default:    s = 2'd3;
            endcase
            waits = int'($urandom_range(0, 3));
            model(a, d, s, ill, ma, wd, be);
            issue(a, d, s);
            if (ill) check_err();
            else begin
                finish_write(ma, wd, be, waits);
                idle_step();
            end
        end

        // Back-to-back: second request presented in the done cycle
        issue(16'h0040, 16'h1111, SZ_HALF);
        finish_write(16'h0040, 16'h1111, 2'b11, 3);
        issue(16'h0043, 16'h00C3, SZ_BYTE);
        chk("b2b_done_cleared", 32'(bus.done), 32'd0);
        finish_write(16'h0042, 16'hC3C3, 2'b10, 0);
        idle_step();
`endif

        // Reset during a stalled write
        issue(16'h0060, 16'hCAFE, SZ_HALF);
        chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we_drop", 32'(bus.mem_we), 32'd0);
        chk("async_addr_clr", 32'(bus.mem_addr), 32'd0);
        chk("async_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle_step();
        issue(16'h0050, 16'hA5A5, SZ_HALF);
        finish_write(16'h0050, 16'hA5A5, 2'b11, 1);
        idle_step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
